// File: rtl/spi_coeff_bridge.sv
// spi_coeff_bridge: SPI mode-0 slave that turns 24-bit host frames into
// one-clk coefficient bus transactions for dsp_top and returns read data
// on miso within the same frame. SPI pins are oversampled in the clk domain.
module spi_coeff_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int READ_LAT    = 2
) (
    input  logic       clk,
    input  logic       rst_n_sync_wire,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] coeff_read_out,
    output logic       msg_in,
    output logic       coeff_rw,
    output logic [9:0] coeff_addr,
    output logic [7:0] coeff_in,
    output logic       frame_err
);

    localparam int WW = $clog2(READ_LAT + 1) + 1;

    typedef enum logic [2:0] {IDLE, SHIFT, RD_REQ, RD_WAIT, WR_REQ} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [4:0]             bit_cnt;
    logic [17:0]            rx;
    logic                   rw_q, rd_done, aborted_q, rd_loaded;
    logic [WW-1:0]          wait_cnt;
    logic [7:0]             tx;
    logic                   in_frame, last_bit, abort_now;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    assign in_frame  = (state == SHIFT) || (state == RD_REQ) || (state == RD_WAIT);
    // A cs_n rise together with the 24th sclk rise still completes the frame.
    assign last_bit  = (bit_cnt == 5'd23) && sclk_rise;
    assign abort_now = in_frame && cs_rise && (bit_cnt != 5'd24) && !last_bit;

    // Synchronise the SPI pins and keep one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n_sync_wire) begin
        if (!rst_n_sync_wire) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n_sync_wire) begin
        if (!rst_n_sync_wire) state <= IDLE;
        else                  state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = SHIFT;
            SHIFT: begin
                if (abort_now)
                    state_next = IDLE;
                else if ((bit_cnt == 5'd16) && !rw_q && !rd_done)
                    state_next = RD_REQ;
                else if (bit_cnt == 5'd24)
                    state_next = rw_q ? WR_REQ : IDLE;
            end
            RD_REQ:  state_next = RD_WAIT;
            RD_WAIT: begin
                if (wait_cnt == WW'(READ_LAT))
                    state_next = (aborted_q || abort_now) ? IDLE : SHIFT;
            end
            WR_REQ:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus strobes follow the request states; miso only carries loaded read data.
    always_comb begin
        msg_in   = (state == RD_REQ) || (state == WR_REQ);
        coeff_rw = (state == WR_REQ);
        miso     = rd_loaded & ~cs_n & tx[7];
    end

    // Frame datapath: bit capture, read-data capture/shift, bus address/data, error flag.
    always_ff @(posedge clk or negedge rst_n_sync_wire) begin
        if (!rst_n_sync_wire) begin
            bit_cnt    <= '0;
            rx         <= '0;
            rw_q       <= 1'b0;
            rd_done    <= 1'b0;
            aborted_q  <= 1'b0;
            rd_loaded  <= 1'b0;
            wait_cnt   <= '0;
            tx         <= '0;
            coeff_addr <= '0;
            coeff_in   <= '0;
            frame_err  <= 1'b0;
        end else if (state == IDLE) begin
            rd_loaded <= 1'b0;
            if (cs_fall) begin
                bit_cnt   <= '0;
                rx        <= '0;
                rw_q      <= 1'b0;
                rd_done   <= 1'b0;
                aborted_q <= 1'b0;
            end
        end else begin
            // Bits keep arriving while the read request is in flight.
            if (in_frame && sclk_rise && (bit_cnt < 5'd24)) begin
                rx      <= {rx[16:0], mosi_s};
                bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd0) rw_q <= mosi_s;
            end
            if (abort_now) begin
                aborted_q <= 1'b1;
                frame_err <= 1'b1;
            end
            if ((state == SHIFT) && (state_next == RD_REQ))
                coeff_addr <= rx[9:0];
            if ((state == SHIFT) && (state_next == WR_REQ)) begin
                coeff_addr <= rx[17:8];
                coeff_in   <= rx[7:0];
            end
            if (state == RD_REQ) begin
                rd_done  <= 1'b1;
                wait_cnt <= WW'(1);
            end
            if (state == RD_WAIT) begin
                if (wait_cnt == WW'(READ_LAT)) begin
                    tx        <= coeff_read_out;
                    rd_loaded <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + WW'(1);
                end
            end
            // Bit 17 is presented on load; later falling edges advance the data.
            if (rd_loaded && sclk_fall && (bit_cnt >= 5'd17))
                tx <= {tx[6:0], 1'b0};
        end
    end

endmodule
